// File: rtl/hid_pkg.sv
// Shared types, report-length constants and saturating accumulator arithmetic
// for the HID report collector.
package hid_pkg;

  typedef enum logic {KBD = 1'b0, MOUSE = 1'b1} hid_dev_t;

  typedef enum logic [1:0] {P_IDLE, P_KBD, P_MOUSE, P_DROP} parser_state_t;

  localparam int KBD_REPORT_LEN = 8;
  localparam int MOUSE_MIN_LEN  = 3;
  localparam int MOUSE_MAX_LEN  = 4;

  // Operands are sign-extended to 64 bits so the sum never wraps before the clamp.
  // The result is clamped to the signed range of an acc_w-bit accumulator.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] delta,
                                                 input int acc_w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (acc_w - 1));
    sum = acc + delta;
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/sync_pulse.sv
// Multi-flop synchronizer for a slow asynchronous level.
// Provides the synchronized level plus single-cycle rise and fall strobes.
module sync_pulse #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/hid_report_collector.sv
// Parses boot-protocol keyboard/mouse reports, keeps live HID state and
// presents a read snapshot that stays frozen while the SPI side reads it.
module hid_report_collector
  import hid_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACC_W       = 32,
  parameter int KEY_SLOTS   = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    rx_sop,
  input  logic                    rx_eop,
  input  logic                    rx_dev,
  input  logic                    kbd_present,
  input  logic                    mouse_present,
  input  logic                    hid_read,
  output logic                    hid_keyboard_connected,
  output logic                    hid_mouse_connected,
  output logic [7:0]              hid_keyboard_modifiers,
  output logic [7:0]              hid_keyboard_keycodes [KEY_SLOTS],
  output logic [7:0]              hid_mouse_buttons,
  output logic signed [ACC_W-1:0] hid_mouse_x,
  output logic signed [ACC_W-1:0] hid_mouse_y,
  output logic signed [ACC_W-1:0] hid_mouse_wheel,
  output logic                    parse_error
);

  parser_state_t state, state_n;
  logic [3:0] idx, idx_n, byte_idx;
  logic wr_kbd, wr_mouse, kbd_commit, mouse_commit, perr;

  logic [7:0]        sh_mod, sh_btn;
  logic [7:0]        sh_keys  [KEY_SLOTS];
  logic [7:0]        keys_new [KEY_SLOTS];
  logic signed [7:0] sh_dx, sh_dy, dy_cur, dw_cur;

  logic [7:0]              live_mod, live_btn;
  logic [7:0]              live_keys [KEY_SLOTS];
  logic signed [ACC_W-1:0] acc_x, acc_y, acc_w;

  logic rd_s, rd_rise, rd_fall, hold;

  function automatic logic signed [ACC_W-1:0] acc_step(input logic signed [ACC_W-1:0] acc,
                                                       input logic signed [7:0] delta,
                                                       input logic signed [ACC_W-1:0] snap);
    return ACC_W'(sat_add(64'(acc), 64'(delta) - 64'(snap), ACC_W));
  endfunction

  sync_pulse #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (hid_read),
    .level   (rd_s),
    .rise    (rd_rise),
    .fall    (rd_fall)
  );

  always_comb begin
    state_n = state; idx_n = idx; byte_idx = idx;
    wr_kbd = 1'b0; wr_mouse = 1'b0;
    kbd_commit = 1'b0; mouse_commit = 1'b0; perr = 1'b0;
    if (rx_valid) begin
      if (rx_sop) begin
        perr     = (state != P_IDLE);
        byte_idx = '0;
        wr_kbd   = (hid_dev_t'(rx_dev) == KBD);
        wr_mouse = (hid_dev_t'(rx_dev) == MOUSE);
        if (rx_eop) begin
          perr    = 1'b1;  // a one-byte report is never a valid length
          state_n = P_IDLE;
          idx_n   = '0;
        end else begin
          state_n = (hid_dev_t'(rx_dev) == MOUSE) ? P_MOUSE : P_KBD;
          idx_n   = 4'd1;
        end
      end else begin
        case (state)
          P_KBD: begin
            wr_kbd = 1'b1;
            if (rx_eop) begin
              state_n = P_IDLE; idx_n = '0;
              if (idx == 4'(KBD_REPORT_LEN - 1)) kbd_commit = 1'b1;
              else                               perr = 1'b1;
            end else if (idx == 4'(KBD_REPORT_LEN - 1)) begin
              state_n = P_DROP; idx_n = '0; perr = 1'b1;
            end else begin
              idx_n = idx + 4'd1;
            end
          end
          P_MOUSE: begin
            wr_mouse = 1'b1;
            if (rx_eop) begin
              state_n = P_IDLE; idx_n = '0;
              if (idx == 4'(MOUSE_MIN_LEN - 1) || idx == 4'(MOUSE_MAX_LEN - 1)) mouse_commit = 1'b1;
              else perr = 1'b1;
            end else if (idx == 4'(MOUSE_MAX_LEN - 1)) begin
              state_n = P_DROP; idx_n = '0; perr = 1'b1;
            end else begin
              idx_n = idx + 4'd1;
            end
          end
          P_DROP: begin
            if (rx_eop) begin
              state_n = P_IDLE; idx_n = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The final byte of a report is used directly, so commit happens on the eop edge.
  always_comb begin
    for (int i = 0; i < KEY_SLOTS; i++)
      keys_new[i] = (i == KBD_REPORT_LEN - 3) ? rx_data : sh_keys[i];
    dy_cur = (idx == 4'(MOUSE_MIN_LEN - 1)) ? signed'(rx_data) : sh_dy;
    dw_cur = (idx == 4'(MOUSE_MAX_LEN - 1)) ? signed'(rx_data) : 8'sd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= P_IDLE;
      idx    <= '0;
      sh_mod <= '0; sh_btn <= '0; sh_dx <= '0; sh_dy <= '0;
      for (int i = 0; i < KEY_SLOTS; i++) sh_keys[i] <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (wr_kbd) begin
        if (byte_idx == 4'd0) sh_mod <= rx_data;
        for (int i = 0; i < KEY_SLOTS; i++)
          if (byte_idx == 4'(i + 2)) sh_keys[i] <= rx_data;
      end
      if (wr_mouse) begin
        if (byte_idx == 4'd0) sh_btn <= rx_data;
        if (byte_idx == 4'd1) sh_dx  <= signed'(rx_data);
        if (byte_idx == 4'd2) sh_dy  <= signed'(rx_data);
      end
    end
  end

  // Snapshot held from the cycle after the rise through the fall cycle itself.
  assign hold = (rd_s & ~rd_rise) | rd_fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      live_mod <= '0; live_btn <= '0;
      acc_x <= '0; acc_y <= '0; acc_w <= '0;
      for (int i = 0; i < KEY_SLOTS; i++) live_keys[i] <= '0;
    end else begin
      if (kbd_commit) begin
        live_mod <= sh_mod;
        for (int i = 0; i < KEY_SLOTS; i++) live_keys[i] <= keys_new[i];
      end
      if (mouse_commit) live_btn <= sh_btn;
      acc_x <= acc_step(acc_x, mouse_commit ? sh_dx  : 8'sd0, rd_fall ? hid_mouse_x     : '0);
      acc_y <= acc_step(acc_y, mouse_commit ? dy_cur : 8'sd0, rd_fall ? hid_mouse_y     : '0);
      acc_w <= acc_step(acc_w, mouse_commit ? dw_cur : 8'sd0, rd_fall ? hid_mouse_wheel : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      parse_error <= 1'b0;
      hid_keyboard_connected <= 1'b0; hid_mouse_connected <= 1'b0;
      hid_keyboard_modifiers <= '0;   hid_mouse_buttons   <= '0;
      hid_mouse_x <= '0; hid_mouse_y <= '0; hid_mouse_wheel <= '0;
      for (int i = 0; i < KEY_SLOTS; i++) hid_keyboard_keycodes[i] <= '0;
    end else begin
      parse_error <= perr;
      if (!hold) begin
        hid_keyboard_connected <= kbd_present;
        hid_mouse_connected    <= mouse_present;
        hid_keyboard_modifiers <= live_mod;
        hid_mouse_buttons      <= live_btn;
        hid_mouse_x            <= acc_x;
        hid_mouse_y            <= acc_y;
        hid_mouse_wheel        <= acc_w;
        for (int i = 0; i < KEY_SLOTS; i++) hid_keyboard_keycodes[i] <= live_keys[i];
      end
    end
  end

endmodule

// File: tb/tb_hid_report_collector.sv
// Bench for hid_report_collector: directed plan steps plus randomized reports,
// checked against a report-level model; a narrow-accumulator copy exercises saturation.
module tb_hid_report_collector;
  localparam int SW = 10;

  logic clk = 1'b0, reset_n = 1'b0;
  logic rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_dev = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic kbd_present = 1'b0, mouse_present = 1'b0, hid_read = 1'b0;

  logic kc, mc, perr, kc_s, mc_s, perr_s;
  logic [7:0] mods, btns, mods_s, btns_s;
  logic [7:0] keys [6];
  logic [7:0] keys_s [6];
  logic signed [31:0]   ox, oy, ow;
  logic signed [SW-1:0] sx_o, sy_o, sw_o;

  hid_report_collector dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_dev(rx_dev),
    .kbd_present(kbd_present), .mouse_present(mouse_present), .hid_read(hid_read),
    .hid_keyboard_connected(kc), .hid_mouse_connected(mc),
    .hid_keyboard_modifiers(mods), .hid_keyboard_keycodes(keys),
    .hid_mouse_buttons(btns), .hid_mouse_x(ox), .hid_mouse_y(oy),
    .hid_mouse_wheel(ow), .parse_error(perr));

  hid_report_collector #(.ACC_W(SW)) dut_s (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_dev(rx_dev),
    .kbd_present(kbd_present), .mouse_present(mouse_present), .hid_read(hid_read),
    .hid_keyboard_connected(kc_s), .hid_mouse_connected(mc_s),
    .hid_keyboard_modifiers(mods_s), .hid_keyboard_keycodes(keys_s),
    .hid_mouse_buttons(btns_s), .hid_mouse_x(sx_o), .hid_mouse_y(sy_o),
    .hid_mouse_wheel(sw_o), .parse_error(perr_s));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, perr_cnt = 0, exp_perr = 0;

  always @(negedge clk) if (perr === 1'b1) perr_cnt++;

  // Reference model: live state plus the expected output values.
  logic [7:0] mmod, mbtn, e_mod, e_btn;
  logic [7:0] mkeys [6];
  logic [7:0] e_keys [6];
  longint mx, my, mw, sx, sy, sw, e_x, e_y, e_w, e_sx, e_sy, e_sw;
  logic e_kc, e_mc;
  logic [7:0] buf_b [16];

  function automatic longint clampw(longint v, int w);
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint lo = -(longint'(1) << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint sb(logic [7:0] b);
    byte d;
    d = b;
    return longint'(d);
  endfunction

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mmod = 0; mbtn = 0; mx = 0; my = 0; mw = 0; sx = 0; sy = 0; sw = 0;
    for (int i = 0; i < 6; i++) mkeys[i] = 0;
  endtask

  task automatic expect_live();
    e_mod = mmod; e_btn = mbtn; e_x = mx; e_y = my; e_w = mw;
    e_sx = sx; e_sy = sy; e_sw = sw; e_kc = kbd_present; e_mc = mouse_present;
    for (int i = 0; i < 6; i++) e_keys[i] = mkeys[i];
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_mod"}, mods, e_mod);
    for (int i = 0; i < 6; i++) check($sformatf("%s_key%0d", tag, i), keys[i], e_keys[i]);
    check({tag, "_btn"}, btns, e_btn);
    check({tag, "_x"}, ox, e_x);
    check({tag, "_y"}, oy, e_y);
    check({tag, "_w"}, ow, e_w);
    check({tag, "_sx"}, sx_o, e_sx);
    check({tag, "_sy"}, sy_o, e_sy);
    check({tag, "_sw"}, sw_o, e_sw);
    check({tag, "_kc"}, kc, e_kc);
    check({tag, "_mc"}, mc, e_mc);
  endtask

  // Drives buf_b[0..len-1] on consecutive cycles; starts and ends at a negedge.
  task automatic drive_bytes(input logic dev, input int len, input bit with_eop);
    for (int i = 0; i < len; i++) begin
      rx_valid = 1'b1; rx_data = buf_b[i]; rx_dev = dev;
      rx_sop = (i == 0); rx_eop = with_eop && (i == len - 1);
      @(negedge clk);
    end
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic mouse_update(input int len);
    mbtn = buf_b[0];
    mx = clampw(mx + sb(buf_b[1]), 32); sx = clampw(sx + sb(buf_b[1]), SW);
    my = clampw(my + sb(buf_b[2]), 32); sy = clampw(sy + sb(buf_b[2]), SW);
    if (len == 4) begin
      mw = clampw(mw + sb(buf_b[3]), 32); sw = clampw(sw + sb(buf_b[3]), SW);
    end
  endtask

  task automatic send_report(input logic dev, input int len);
    drive_bytes(dev, len, 1'b1);
    if (dev == 1'b0) begin
      if (len == 8) begin
        mmod = buf_b[0];
        for (int i = 0; i < 6; i++) mkeys[i] = buf_b[2 + i];
      end else exp_perr++;
    end else begin
      if (len == 3 || len == 4) mouse_update(len);
      else exp_perr++;
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic read_fall_model();
    mx = clampw(mx - e_x, 32);  my = clampw(my - e_y, 32);  mw = clampw(mw - e_w, 32);
    sx = clampw(sx - e_sx, SW); sy = clampw(sy - e_sy, SW); sw = clampw(sw - e_sw, SW);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) buf_b[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    kbd_present = 1'b1; mouse_present = 1'b1;
    repeat (3) @(negedge clk);
    // reset state: everything zero even with devices present
    e_mod = 0; e_btn = 0; e_x = 0; e_y = 0; e_w = 0; e_sx = 0; e_sy = 0; e_sw = 0;
    e_kc = 0; e_mc = 0;
    for (int i = 0; i < 6; i++) e_keys[i] = 0;
    check_outs("rst");
    check("rst_perr", perr, 0);
    reset_n = 1'b1;
    settle();

    // 1: keyboard report
    buf_b[0] = 8'h02; buf_b[1] = 8'h00; buf_b[2] = 8'h04; buf_b[3] = 8'h05;
    buf_b[4] = 8'h00; buf_b[5] = 8'h00; buf_b[6] = 8'h00; buf_b[7] = 8'h00;
    send_report(1'b0, 8); settle();
    expect_live(); check_outs("t1");
    check("t1_mod_const", mods, 8'h02);
    check("t1_key0_const", keys[0], 8'h04);
    check("t1_key1_const", keys[1], 8'h05);
    check("t1_perr", perr_cnt, 0);

    // 2: 4-byte then 3-byte mouse reports
    buf_b[0] = 8'h01; buf_b[1] = 8'h05; buf_b[2] = 8'hFD; buf_b[3] = 8'h01;
    send_report(1'b1, 4);
    buf_b[0] = 8'h00; buf_b[1] = 8'h05; buf_b[2] = 8'hFD;
    send_report(1'b1, 3); settle();
    expect_live(); check_outs("t2");
    check("t2_x_const", ox, 10); check("t2_y_const", oy, -6);
    check("t2_w_const", ow, 1);  check("t2_btn_const", btns, 0);

    // 3: movement during a read window survives the subtract
    hid_read = 1'b1; repeat (5) @(negedge clk);
    expect_live();
    buf_b[0] = 8'h00; buf_b[1] = 8'h03; buf_b[2] = 8'h00;
    send_report(1'b1, 3); settle();
    check_outs("t3_hold");
    check("t3_hold_x_const", ox, 10);
    hid_read = 1'b0; repeat (5) @(negedge clk);
    read_fall_model(); expect_live(); check_outs("t3_after");
    check("t3_x_const", ox, 3); check("t3_y_const", oy, 0);

    // 4: commit on the same edge as the subtract
    buf_b[0] = 8'h00; buf_b[1] = 8'h07; buf_b[2] = 8'h00;
    send_report(1'b1, 3); settle();
    hid_read = 1'b1; repeat (5) @(negedge clk);
    expect_live();
    check("t4_snap_x", ox, 10);
    buf_b[0] = 8'h00; buf_b[1] = 8'hFE; buf_b[2] = 8'h00;
    hid_read = 1'b0;
    drive_bytes(1'b1, 3, 1'b1);
    mbtn = 8'h00;
    mx = clampw(mx - e_x - 2, 32); my = clampw(my - e_y, 32); mw = clampw(mw - e_w, 32);
    sx = clampw(sx - e_sx - 2, SW); sy = clampw(sy - e_sy, SW); sw = clampw(sw - e_sw, SW);
    repeat (4) @(negedge clk);
    expect_live(); check_outs("t4");
    check("t4_x_const", ox, -2);

    // 5: short keyboard report, then a mouse report cut short by a new sop
    fill_random(6); send_report(1'b0, 6);
    buf_b[0] = 8'h00; buf_b[1] = 8'h11;
    drive_bytes(1'b1, 2, 1'b0); exp_perr++;
    buf_b[0] = 8'h00; buf_b[1] = 8'h00; buf_b[2] = 8'h00;
    send_report(1'b1, 3); settle();
    expect_live(); check_outs("t5");
    check("t5_perr", perr_cnt, exp_perr);
    check("t5_mod_const", mods, 8'h02);

    // randomized mix of reports, bad lengths, stray bytes and read windows
    for (int it = 0; it < 30; it++) begin
      int op, len;
      logic dev;
      kbd_present = 1'($urandom_range(0, 1));
      mouse_present = 1'($urandom_range(0, 1));
      @(negedge clk);
      op = $urandom_range(0, 4);
      case (op)
        0: begin fill_random(8); send_report(1'b0, 8); settle(); end
        1: begin
          len = $urandom_range(3, 4); fill_random(len);
          send_report(1'b1, len); settle();
        end
        2: begin
          dev = 1'($urandom_range(0, 1));
          if (dev) begin len = $urandom_range(1, 4); if (len >= 3) len += 2; end
          else begin len = $urandom_range(1, 9); if (len >= 8) len++; end
          fill_random(len); send_report(dev, len); settle();
        end
        3: begin
          hid_read = 1'b1; repeat (5) @(negedge clk);
          expect_live();
          len = $urandom_range(3, 4); fill_random(len);
          send_report(1'b1, len); settle();
          check_outs("rnd_hold");
          hid_read = 1'b0; repeat (5) @(negedge clk);
          read_fall_model();
        end
        default: begin
          fill_random(2);
          rx_valid = 1'b1; rx_data = buf_b[0]; @(negedge clk);
          rx_data = buf_b[1]; @(negedge clk);
          rx_valid = 1'b0; settle();
        end
      endcase
      expect_live(); check_outs($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_perr", it), perr_cnt, exp_perr);
    end

    // 6: saturation on the narrow copy, then a one-cycle reset
    for (int k = 0; k < 10; k++) begin
      buf_b[0] = 8'h00; buf_b[1] = 8'h7F; buf_b[2] = 8'h80; buf_b[3] = 8'h7F;
      send_report(1'b1, 4);
    end
    settle();
    expect_live(); check_outs("t6");
    check("t6_sx_max", sx_o, 511);
    check("t6_sy_min", sy_o, -512);
    check("t6_sw_max", sw_o, 511);
    kbd_present = 1'b1; mouse_present = 1'b1;
    reset_n = 1'b0; @(negedge clk);
    model_reset();
    e_mod = 0; e_btn = 0; e_x = 0; e_y = 0; e_w = 0; e_sx = 0; e_sy = 0; e_sw = 0;
    e_kc = 0; e_mc = 0;
    for (int i = 0; i < 6; i++) e_keys[i] = 0;
    check_outs("t6_rst");
    reset_n = 1'b1; settle();
    expect_live(); check_outs("t6_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
